// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: IF fetch vs MEM load/store, one access in flight.
// Data side wins ties unless fetch has waited MAX_DGRANTS data grants.
module mem_port_arbiter #(
  parameter int XLEN        = 64,
  parameter int MAX_DGRANTS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [31:0]     if_rdata,
  output logic            if_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [7:0]      d_wstrb,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  output logic [7:0]      m_wstrb,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata
);

  localparam int CW = $clog2(MAX_DGRANTS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DGRANTS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            own_d;
  logic            own_d_nx;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_nx;
  logic            grant;
  logic            grant_d;
  logic            capture;
  logic            fetch_due;

  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      wstrb_q;
  logic            unused_lo;

  assign unused_lo = ^addr_q[1:0];
  assign fetch_due = if_req && (starve_cnt == MAX_CNT);

  assign m_valid = (state == REQ);
  assign m_we    = we_q;
  assign m_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign m_wdata = wdata_q;
  assign m_wstrb = wstrb_q;

  always_comb begin
    state_nx  = state;
    own_d_nx  = own_d;
    starve_nx = starve_cnt;
    grant     = 1'b0;
    grant_d   = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!if_req) starve_nx = '0;
        if (d_req || if_req) begin
          grant    = 1'b1;
          grant_d  = d_req && !fetch_due;
          own_d_nx = grant_d;
          state_nx = REQ;
          if (!grant_d) begin
            starve_nx = '0;
          end else if (if_req && starve_cnt != MAX_CNT) begin
            starve_nx = starve_cnt + 1'b1;
          end
        end
      end
      REQ: begin
        if (m_ready) begin
          if (we_q) begin
            state_nx = DONE;
          end else if (m_rvalid) begin
            capture  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (m_rvalid) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 8'h00;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      state      <= state_nx;
      own_d      <= own_d_nx;
      starve_cnt <= starve_nx;
      if (grant) begin
        we_q    <= grant_d && d_we;
        addr_q  <= grant_d ? d_addr : if_addr;
        wdata_q <= grant_d ? d_wdata : '0;
        wstrb_q <= (grant_d && d_we) ? d_wstrb : 8'h00;
      end
      if (capture) begin
        if (own_d) begin
          d_rdata <= m_rdata;
        end else begin
          if_rdata <= addr_q[2] ? m_rdata[63:32]
                                : m_rdata[31:0];
        end
      end
      // Pulses line up with the DONE state cycle.
      if_done <= (state_nx == DONE) && !own_d;
      d_done  <= (state_nx == DONE) && own_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [31:0]     if_rdata;
  logic            if_done;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [7:0]      d_wstrb;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            m_valid;
  logic            m_ready;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [7:0]      m_wstrb;
  logic            m_rvalid;
  logic [XLEN-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(64), .MAX_DGRANTS(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  typedef struct packed {
    logic        is_d;
    logic [63:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          errs = 0;
  int          rdy_dly = 0;
  int          rv_dly = 1;
  logic [63:0] rsp_data = '0;
  logic        rsp_we;
  exp_t        mon_e;
  int          n;

  function automatic void chk(string nm, logic [63:0] got,
                              logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (if_done || d_done) begin
      if (sbq.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_done: got if=%b d=%b expected none",
                 if_done, d_done);
      end else begin
        mon_e = sbq.pop_front();
        chk("one_done", {63'd0, if_done & d_done}, 64'd0);
        chk("done_owner", {63'd0, d_done}, {63'd0, mon_e.is_d});
        if (mon_e.is_d) chk("d_rdata", d_rdata, mon_e.data);
        else chk("if_rdata", {32'd0, if_rdata}, mon_e.data);
      end
    end
  end

  // Memory responder: ready after rdy_dly cycles, read data rv_dly after accept.
  initial begin
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (m_valid === 1'b1) begin
        rsp_we = m_we;
        repeat (rdy_dly) begin @(posedge clk); #1; end
        m_ready = 1'b1;
        if (!rsp_we && rv_dly == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = rsp_data;
        end
        @(posedge clk); #1;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        if (!rsp_we && rv_dly > 0) begin
          repeat (rv_dly - 1) begin @(posedge clk); #1; end
          m_rvalid = 1'b1;
          m_rdata  = rsp_data;
          @(posedge clk); #1;
          m_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm, output int cnt);
    cnt = 0;
    while (!(if_done || d_done) && cnt < 50) begin
      tick();
      cnt++;
    end
    chk(nm, {63'd0, if_done | d_done}, 64'd1);
  endtask

  initial begin
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_m_wstrb", {56'd0, m_wstrb}, 64'd0);
    chk("rst_done", {62'd0, if_done, d_done}, 64'd0);
    chk("rst_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);

    // Fetch, upper word, response 2 cycles after accept
    rsp_data = 64'hAABBCCDD_11223344;
    rv_dly   = 2;
    if_addr  = 64'h1004;
    if_req   = 1'b1;
    sbq.push_back('{1'b0, 64'h0000_0000_AABB_CCDD});
    tick();
    chk("f_m_valid", {63'd0, m_valid}, 64'd1);
    chk("f_m_addr", m_addr, 64'h1000);
    chk("f_m_wstrb", {56'd0, m_wstrb}, 64'd0);
    chk("f_m_we", {63'd0, m_we}, 64'd0);
    wait_done("f_done", n);
    if_req = 1'b0;
    tick();
    chk("f_done_pulse", {63'd0, if_done}, 64'd0);

    // Zero-latency load
    rsp_data = 64'h55AA1234_DEADBEEF;
    rv_dly   = 0;
    d_addr   = 64'h3010;
    d_we     = 1'b0;
    d_req    = 1'b1;
    sbq.push_back('{1'b1, 64'h55AA1234_DEADBEEF});
    wait_done("zl_done", n);
    chk("zl_latency", 64'(n), 64'd2);
    d_req = 1'b0;
    tick();

    // Store with ready held low 3 cycles
    rdy_dly = 3;
    d_we    = 1'b1;
    d_addr  = 64'h2009;
    d_wdata = 64'h0000_0000_0000_AB00;
    d_wstrb = 8'h02;
    d_req   = 1'b1;
    sbq.push_back('{1'b1, 64'h55AA1234_DEADBEEF});
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("st_m_valid", {63'd0, m_valid}, 64'd1);
      chk("st_m_addr", m_addr, 64'h2008);
      tick();
    end
    chk("st_m_we", {63'd0, m_we}, 64'd1);
    chk("st_m_wstrb", {56'd0, m_wstrb}, 64'h02);
    chk("st_m_wdata", m_wdata, 64'hAB00);
    tick();
    chk("st_done_lat", {63'd0, d_done}, 64'd1);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    chk("st_done_pulse", {63'd0, d_done}, 64'd0);

    // Both requesting: D,D,D,D,F,D
    rdy_dly  = 0;
    rv_dly   = 1;
    rsp_data = 64'h01234567_89ABCDEF;
    if_addr  = 64'h1000;
    d_addr   = 64'h4000;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) sbq.push_back('{1'b0, 64'h89ABCDEF});
      else sbq.push_back('{1'b1, 64'h01234567_89ABCDEF});
    end
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_done("arb_done", n);
      if (k < 5) tick();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();

    // Held d_req re-arbitrates after one bubble
    rsp_data = 64'hFEDCBA98_76543210;
    d_addr   = 64'h5008;
    sbq.push_back('{1'b1, 64'hFEDCBA98_76543210});
    sbq.push_back('{1'b1, 64'hFEDCBA98_76543210});
    d_req = 1'b1;
    wait_done("hold_done1", n);
    tick();
    chk("bubble_idle", {63'd0, m_valid}, 64'd0);
    tick();
    chk("bubble_req", {63'd0, m_valid}, 64'd1);
    wait_done("hold_done2", n);
    d_req = 1'b0;
    tick();

    // Reset in WAIT_R, late response must be dropped
    rv_dly   = 4;
    rsp_data = 64'h11111111_22222222;
    d_addr   = 64'h6000;
    d_req    = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    chk("rw_valid", {63'd0, m_valid}, 64'd1);
    n = 0;
    while (m_valid && n < 20) begin tick(); n++; end
    chk("rw_accept", {63'd0, m_valid}, 64'd0);
    d_req = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rw_done", {62'd0, if_done, d_done}, 64'd0);
      chk("rw_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rw_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
      chk("rw_m_addr", m_addr, 64'd0);
      tick();
    end

    repeat (4) tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
